food_spawner: RTL

Consumer of the 5-bit pseudo-random stream in the snake game. On a spawn request it draws candidate (x, y) cells from the stream, range-checks each one, and checks it against the snake body through an occupancy query port. The first free cell is published as the new food position. If too many random draws fail, it falls back to a deterministic raster scan. It sits between the random number generator and the game-state/renderer logic.

---
 rtl/food_spawner_if.sv | 29 ++
 rtl/food_spawner.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/food_spawner_if.sv
// Bundle between the food spawner, the random source, the occupancy map and game state.
// Suffixes are relative to the spawner: _i flows into it, _o flows out of it.
interface food_spawner_if;
    logic [4:0] rand_i;
    logic       spawn_req_i;
    logic       occ_hit_i;
    logic       busy_o;
    logic       occ_valid_o;
    logic [4:0] occ_x_o;
    logic [4:0] occ_y_o;
    logic [4:0] food_x_o;
    logic [4:0] food_y_o;
    logic       food_valid_o;
    logic       fail_o;

    // Handshake: occ_valid_o is a one-cycle query strobe with occ_x_o/occ_y_o stable
    // alongside it; the responder holds occ_hit_i valid for the whole following cycle.
    modport slave (
        input  rand_i, spawn_req_i, occ_hit_i,
        output busy_o, occ_valid_o, occ_x_o, occ_y_o,
        output food_x_o, food_y_o, food_valid_o, fail_o
    );

    modport master (
        output rand_i, spawn_req_i, occ_hit_i,
        input  busy_o, occ_valid_o, occ_x_o, occ_y_o,
        input  food_x_o, food_y_o, food_valid_o, fail_o
    );
endinterface

// File: rtl/food_spawner.sv
// Places food on a free grid cell: random candidates first, then a raster scan fallback.
// state_dbg_o exposes the FSM encoding (IDLE=0 .. SCAN_W=6).
module food_spawner #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int MAX_TRIES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    food_spawner_if.slave        fs,
    output logic [2:0]           state_dbg_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_X  = 3'd1,
        GET_Y  = 3'd2,
        QUERY  = 3'd3,
        WAIT   = 3'd4,
        SCAN_Q = 3'd5,
        SCAN_W = 3'd6
    } state_e;

    localparam logic [5:0] GW        = 6'(GRID_W);
    localparam logic [5:0] GH        = 6'(GRID_H);
    localparam logic [4:0] X_LAST    = 5'(GRID_W - 1);
    localparam logic [4:0] Y_LAST    = 5'(GRID_H - 1);
    localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

    state_e     state_q, state_d;
    logic [3:0] tries_q, tries_d;
    logic [4:0] cand_x_q, cand_x_d;
    logic [4:0] occ_x_q, occ_x_d;
    logic [4:0] occ_y_q, occ_y_d;
    logic [4:0] food_x_q, food_x_d;
    logic [4:0] food_y_q, food_y_d;
    logic       food_valid_q, food_valid_d;
    logic       fail_q, fail_d;
    logic       reject;
    logic [3:0] tries_inc;

    assign tries_inc = tries_q + 4'd1;

    // occ_x_q/occ_y_q double as the scan position, so the query port always shows registers.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        cand_x_d     = cand_x_q;
        occ_x_d      = occ_x_q;
        occ_y_d      = occ_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = 1'b0;
        fail_d       = 1'b0;
        reject       = 1'b0;

        case (state_q)
            IDLE: begin
                if (fs.spawn_req_i) begin
                    tries_d = 4'd0;
                    state_d = GET_X;
                end
            end
            GET_X: begin
                cand_x_d = fs.rand_i;
                state_d  = GET_Y;
            end
            GET_Y: begin
                if (({1'b0, cand_x_q} >= GW) || ({1'b0, fs.rand_i} >= GH)) begin
                    reject = 1'b1;
                end else begin
                    occ_x_d = cand_x_q;
                    occ_y_d = fs.rand_i;
                    state_d = QUERY;
                end
            end
            QUERY: state_d = WAIT;
            WAIT: begin
                if (!fs.occ_hit_i) begin
                    food_x_d     = occ_x_q;
                    food_y_d     = occ_y_q;
                    food_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    reject = 1'b1;
                end
            end
            SCAN_Q: state_d = SCAN_W;
            SCAN_W: begin
                if (!fs.occ_hit_i) begin
                    food_x_d     = occ_x_q;
                    food_y_d     = occ_y_q;
                    food_valid_d = 1'b1;
                    state_d      = IDLE;
                end else if (occ_x_q == X_LAST && occ_y_q == Y_LAST) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else if (occ_x_q == X_LAST) begin
                    occ_x_d = 5'd0;
                    occ_y_d = occ_y_q + 5'd1;
                    state_d = SCAN_Q;
                end else begin
                    occ_x_d = occ_x_q + 5'd1;
                    state_d = SCAN_Q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Range rejects and occupancy hits share one retry budget.
        if (reject) begin
            tries_d = tries_inc;
            if (tries_inc == TRY_LIMIT) begin
                occ_x_d = 5'd0;
                occ_y_d = 5'd0;
                state_d = SCAN_Q;
            end else begin
                state_d = GET_X;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tries_q      <= 4'd0;
            cand_x_q     <= 5'd0;
            occ_x_q      <= 5'd0;
            occ_y_q      <= 5'd0;
            food_x_q     <= 5'd0;
            food_y_q     <= 5'd0;
            food_valid_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            cand_x_q     <= cand_x_d;
            occ_x_q      <= occ_x_d;
            occ_y_q      <= occ_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            fail_q       <= fail_d;
        end
    end

    assign fs.busy_o       = (state_q != IDLE);
    assign fs.occ_valid_o  = (state_q == QUERY) || (state_q == SCAN_Q);
    assign fs.occ_x_o      = occ_x_q;
    assign fs.occ_y_o      = occ_y_q;
    assign fs.food_x_o     = food_x_q;
    assign fs.food_y_o     = food_y_q;
    assign fs.food_valid_o = food_valid_q;
    assign fs.fail_o       = fail_q;
    assign state_dbg_o     = state_q;

endmodule
